zxuno_port_ctrl: RTL and testbench
==================================

ZXUNO_PORT_CTRL -- requirements
Module: zxuno_port_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 a  input  16  CPU address bus, synchronous to clk.
REQ-004 iorq_n  input  1  CPU I/O request, active low.
REQ-005 rd_n  input  1  CPU read strobe, active low.
REQ-006 wr_n  input  1  CPU write strobe, active low.
REQ-007 din  input  8  CPU data bus, valid while wr_n low.
REQ-008 zxuno_addr  output  8  current register address, fanned out to all register peripherals.
REQ-009 zxuno_regrd  output  1  level: CPU is reading the data port.
REQ-010 zxuno_regwr  output  1  one-cycle pulse: CPU write to the data port.
REQ-011 regaddr_changed  output  1  one-cycle pulse: address port written.
REQ-012 dout  output  8  readback data for the address port.
REQ-013 oe_n  output  1  active low; dout is to be driven onto the CPU bus.

Function
REQ-014 Address port: a == 16'hFC3B (full 16-bit decode); data port: a == 16'hFD3B.
REQ-015 Read access: iorq_n=0, rd_n=0, wr_n=1. Write access: iorq_n=0, wr_n=0, rd_n=1. rd_n=wr_n=0 together is not an access; ignore it.
REQ-016 Write access is registered each clock (wr_act_q); write start is the first cycle with write access true and wr_act_q false.
REQ-017 Write start on the address port: zxuno_addr <= din at that edge. regaddr_changed is high for exactly the next single cycle, with the new zxuno_addr already visible.
REQ-018 regaddr_changed pulses even when the written value equals the current zxuno_addr.
REQ-019 Write start on the data port: zxuno_regwr is high for exactly one cycle, registered like regaddr_changed. zxuno_addr is unchanged.
REQ-020 A write access held for N cycles produces exactly one pulse. A new pulse requires write access to go false for at least one cycle first.
REQ-021 zxuno_regrd = read access on the data port, combinational, with no latency. It stays high for the full access.
REQ-022 Only reads of the address port drive oe_n low; oe_n is combinational. Data-port reads are answered by the peripherals, not by this block.
REQ-023 dout is a register equal to zxuno_addr, updated every clock.
REQ-024 An address change and a data-port access cannot overlap; the CPU serialises them. No priority logic is required.

Reset
REQ-025 While rst=1: zxuno_addr=8'h00, dout=8'h00, zxuno_regwr=0, regaddr_changed=0, wr_act_q=0.
REQ-026 oe_n and zxuno_regrd remain combinational during reset.
REQ-027 After rst falls, a write access already in progress counts as a new write start.
REQ-028 Reset asserted in the same cycle as a write start wins: no pulse is emitted and the address is not updated.

Configuration
REQ-029 Macro ZXUNO_ADDR_READBACK_EN defined: the address port is readable as per REQ-022/023.
REQ-030 Macro ZXUNO_ADDR_READBACK_EN undefined: oe_n is tied to 1 and dout is tied to 8'h00. All other behaviour is unchanged.

Verification
REQ-031 Write 8'hFF to FC3B for 3 cycles -> zxuno_addr=8'hFF from the next cycle; regaddr_changed high exactly 1 cycle; zxuno_regwr stays 0.
REQ-032 Write 8'h05 to FD3B for 4 cycles -> zxuno_regwr high exactly 1 cycle; zxuno_addr unchanged.
REQ-033 Read FD3B for 3 cycles with zxuno_addr=8'hFF -> zxuno_regrd=1 for exactly those 3 cycles; oe_n=1 throughout.
REQ-034 With the macro defined, write 8'h2A to FC3B, then read FC3B -> oe_n=0 during the read and dout=8'h2A. With the macro undefined -> oe_n=1 and dout=8'h00.
REQ-035 Write 8'h10 to FC3B twice back-to-back with a 1-cycle idle gap -> two regaddr_changed pulses. The same write with no gap (held access) -> one pulse.
REQ-036 Assert rst during a write to FC3B of 8'h33 -> no pulse and zxuno_addr=8'h00. Release rst with the write still active -> one pulse and zxuno_addr=8'h33.

Source files
------------

// File: rtl/zxuno_port_ctrl.sv
// ==========================================================================
// zxuno_port_ctrl : ZX-Uno register address/data port decoder (FC3B/FD3B).
// Optional address readback enabled by macro ZXUNO_ADDR_READBACK_EN.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module zxuno_port_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        regaddr_changed,
  output logic [7:0]  dout,
  output logic        oe_n
);

  localparam logic [15:0] ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] DATA_PORT = 16'hFD3B;

  logic       w_rd_acc;
  logic       w_wr_acc;
  logic       w_wr_start;
  logic       w_is_addr;
  logic       w_is_data;

  logic       wr_act_d,          wr_act_q;
  logic [7:0] zxuno_addr_d,      zxuno_addr_q;
  logic       regaddr_changed_d, regaddr_changed_q;
  logic       zxuno_regwr_d,     zxuno_regwr_q;

  // Both strobes low together is not a valid access of either kind.
  assign w_rd_acc  = !iorq_n && !rd_n &&  wr_n;
  assign w_wr_acc  = !iorq_n && !wr_n &&  rd_n;
  assign w_is_addr = (a == ADDR_PORT);
  assign w_is_data = (a == DATA_PORT);
  assign w_wr_start = w_wr_acc && !wr_act_q;

  always_comb begin
    wr_act_d          = w_wr_acc;
    zxuno_addr_d      = zxuno_addr_q;
    regaddr_changed_d = w_wr_start && w_is_addr;
    zxuno_regwr_d     = w_wr_start && w_is_data;
    if (w_wr_start && w_is_addr) begin
      zxuno_addr_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_act_q          <= 1'b0;
      zxuno_addr_q      <= 8'h00;
      regaddr_changed_q <= 1'b0;
      zxuno_regwr_q     <= 1'b0;
    end else begin
      wr_act_q          <= wr_act_d;
      zxuno_addr_q      <= zxuno_addr_d;
      regaddr_changed_q <= regaddr_changed_d;
      zxuno_regwr_q     <= zxuno_regwr_d;
    end
  end

  assign zxuno_addr      = zxuno_addr_q;
  assign regaddr_changed = regaddr_changed_q;
  assign zxuno_regwr     = zxuno_regwr_q;
  assign zxuno_regrd     = w_rd_acc && w_is_data;

`ifdef ZXUNO_ADDR_READBACK_EN
  logic [7:0] dout_d, dout_q;

  // Track the next address value so dout always equals zxuno_addr.
  always_comb begin
    dout_d = zxuno_addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  assign oe_n = !(w_rd_acc && w_is_addr);
`else
  assign dout = 8'h00;
  assign oe_n = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_zxuno_port_ctrl.sv
// ==========================================================================
// tb_zxuno_port_ctrl : scoreboard bench with a behavioural reference model.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_zxuno_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd, zxuno_regwr, regaddr_changed;
  logic [7:0]  dout;
  logic        oe_n;

  zxuno_port_ctrl dut (
    .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .regaddr_changed(regaddr_changed),
    .dout(dout), .oe_n(oe_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic       regrd;
    logic       regwr;
    logic       changed;
    logic [7:0] dout;
    logic       oe_n;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference state: the register address and whether the CPU was in a
  // write cycle last clock (a pulse fires only on a new write).
  logic [7:0] m_addr = 8'h00;
  bit         m_in_write = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must show afterwards.
  task automatic cyc(input bit r, input logic [15:0] ad, input bit iq,
                     input bit rd, input bit wr, input logic [7:0] d);
    exp_t e;
    bit is_read, is_write, new_write;
    @(negedge clk);
    rst = r; a = ad; iorq_n = iq; rd_n = rd; wr_n = wr; din = d;
    is_read  = !iq && !rd && wr;
    is_write = !iq && !wr && rd;
    e.regrd = is_read && (ad == 16'hFD3B);
`ifdef ZXUNO_ADDR_READBACK_EN
    e.oe_n = !(is_read && (ad == 16'hFC3B));
`else
    e.oe_n = 1'b1;
`endif
    if (r) begin
      m_addr = 8'h00; m_in_write = 1'b0;
      e.changed = 1'b0; e.regwr = 1'b0;
    end else begin
      new_write = is_write && !m_in_write;
      e.changed = new_write && (ad == 16'hFC3B);
      e.regwr   = new_write && (ad == 16'hFD3B);
      if (e.changed) m_addr = d;
      m_in_write = is_write;
    end
    e.addr = m_addr;
`ifdef ZXUNO_ADDR_READBACK_EN
    e.dout = m_addr;
`else
    e.dout = 8'h00;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'h0000, 1, 1, 1, 8'h00);
  endtask

  task automatic wr_port(input logic [15:0] ad, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(0, ad, 0, 1, 0, d);
  endtask

  task automatic rd_port(input logic [15:0] ad, input int n);
    for (int i = 0; i < n; i++) cyc(0, ad, 0, 0, 1, 8'h00);
  endtask

  // Monitor: compare every cycle, one output sample per pending expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("zxuno_addr",      zxuno_addr,             e.addr);
      chk("zxuno_regrd",     {7'd0, zxuno_regrd},    {7'd0, e.regrd});
      chk("zxuno_regwr",     {7'd0, zxuno_regwr},    {7'd0, e.regwr});
      chk("regaddr_changed", {7'd0, regaddr_changed}, {7'd0, e.changed});
      chk("dout",            dout,                   e.dout);
      chk("oe_n",            {7'd0, oe_n},           {7'd0, e.oe_n});
    end
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rdat;
    bit rr, riq, rrd, rwr;
    rst = 1; a = 0; iorq_n = 1; rd_n = 1; wr_n = 1; din = 0;
    cyc(1, 16'h0000, 1, 1, 1, 8'h00);
    cyc(1, 16'h0000, 1, 1, 1, 8'h00);
    idle(2);
    wr_port(16'hFC3B, 8'hFF, 3); idle(2);
    wr_port(16'hFD3B, 8'h05, 4); idle(2);
    rd_port(16'hFD3B, 3); idle(2);
    wr_port(16'hFC3B, 8'h2A, 2); idle(1);
    rd_port(16'hFC3B, 3); idle(2);
    wr_port(16'hFC3B, 8'h10, 1); idle(1); wr_port(16'hFC3B, 8'h10, 1); idle(2);
    wr_port(16'hFC3B, 8'h10, 2); idle(2);
    cyc(0, 16'hFC3B, 0, 0, 0, 8'h77); idle(1);
    cyc(0, 16'hFC3A, 0, 1, 0, 8'h77); idle(1);
    // Reset during a write, then release with the write still active.
    cyc(1, 16'hFC3B, 0, 1, 0, 8'h33);
    cyc(1, 16'hFC3B, 0, 1, 0, 8'h33);
    wr_port(16'hFC3B, 8'h33, 3); idle(2);
    // Randomized phase: inputs are held for random stretches.
    rr = 0; ra = 16'h0000; riq = 1; rrd = 1; rwr = 1; rdat = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 45) begin
        case ($urandom_range(0, 3))
          0: ra = 16'hFC3B;
          1: ra = 16'hFD3B;
          2: ra = 16'hFC3B ^ (16'h1 << $urandom_range(0, 15));
          default: ra = 16'($urandom);
        endcase
        case ($urandom_range(0, 4))
          0: begin riq = 1; rrd = 1; rwr = 1; end
          1: begin riq = 0; rrd = 0; rwr = 1; end
          2, 3: begin riq = 0; rrd = 1; rwr = 0; end
          default: begin riq = 1'($urandom); rrd = 1'($urandom); rwr = 1'($urandom); end
        endcase
        rdat = 8'($urandom);
      end
      rr = ($urandom_range(0, 99) < 3);
      cyc(rr, ra, riq, rrd, rwr, rdat);
    end
    idle(2);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
